// File: rtl/usb2_ep_router_pkg.sv
// usb2_ep_router_pkg: endpoint modes, router FSM states and data PID toggle encodings
package usb2_ep_router_pkg;
    localparam logic [1:0] EP_MODE_CONTROL   = 2'd0;
    localparam logic [1:0] EP_MODE_ISOCH     = 2'd1;
    localparam logic [1:0] EP_MODE_BULK      = 2'd2;
    localparam logic [1:0] EP_MODE_INTERRUPT = 2'd3;
    localparam logic [1:0] DATA0 = 2'b00;
    localparam logic [1:0] DATA1 = 2'b01;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUND  = 2'd1,
        ST_REJECT = 2'd2
    } rtr_state_e;
endpackage

// File: rtl/usb2_ep_router_if.sv
// usb2_ep_router_if: packet-side buffer write/read path; master is the packet layer, slave is the router
interface usb2_ep_router_if #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
);
    logic [ADDR_W-1:0] buf_in_addr;
    logic [7:0]        buf_in_data;
    logic              buf_in_wren;
    logic              buf_in_commit;
    logic [LEN_W-1:0]  buf_in_commit_len;
    logic              buf_in_ready;
    logic              buf_in_commit_ack;
    logic [ADDR_W-1:0] buf_out_addr;
    logic              buf_out_arm;
    logic [7:0]        buf_out_q;
    logic [LEN_W-1:0]  buf_out_len;
    logic              buf_out_hasdata;
    logic              buf_out_arm_ack;
    modport master (
        output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len, buf_out_addr, buf_out_arm,
        input  buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack
    );
    modport slave (
        input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len, buf_out_addr, buf_out_arm,
        output buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack
    );
endinterface

// File: rtl/usb2_ep_router_state.sv
// usb2_ep_state: per-endpoint DATA0/DATA1 toggle and halt bank; clears to DATA0 beat ACK flips, halt set beats clear
module usb2_ep_state #(
    parameter int NUM_EP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_EP-1:0] flip_i,
    input  logic              setup0_i,
    input  logic              halt_set_i,
    input  logic              halt_clr_i,
    input  logic [3:0]        halt_endp_i,
    input  logic              toggle_reset_i,
    output logic [NUM_EP-1:0] tog_o,
    output logic [NUM_EP-1:0] halt_o
);
    logic [NUM_EP-1:0] tog_q, tog_d, halt_q, halt_d;

    always_comb begin
        tog_d  = tog_q;
        halt_d = halt_q;
        for (int i = 0; i < NUM_EP; i++) begin
            tog_d[i]  = (setup0_i && i == 0) || (halt_clr_i && halt_endp_i == 4'(i)) || (toggle_reset_i && i != 0)
                        ? 1'b0 : tog_q[i] ^ flip_i[i];
            halt_d[i] = halt_set_i && halt_endp_i == 4'(i) ? 1'b1
                      : (halt_clr_i && halt_endp_i == 4'(i)) || (setup0_i && i == 0) ? 1'b0 : halt_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tog_q  <= '0;
            halt_q <= '0;
        end else begin
            tog_q  <= tog_d;
            halt_q <= halt_d;
        end
    end

    assign tog_o  = tog_q;
    assign halt_o = halt_q;
endmodule

// File: rtl/usb2_ep_router.sv
// usb2_ep_router: binds one endpoint per token and muxes buffer traffic to it, gating halted/unbound endpoints.
// Define USB2_EP_ROUTER_TIMEOUT_EN to build the bind watchdog that drives err_timeout.
module usb2_ep_router
    import usb2_ep_router_pkg::*;
#(
    parameter int                  NUM_EP   = 4,
    parameter int                  ADDR_W   = 9,
    parameter int                  LEN_W    = 10,
    parameter logic [2*NUM_EP-1:0] EP_MODES = 8'b10_10_10_00,
    parameter int                  TIMEOUT  = 4095
) (
    input  logic                     phy_clk,
    input  logic                     reset,
    input  logic [3:0]               pkt_endp,
    input  logic                     pkt_token_act,
    input  logic                     pkt_setup,
    input  logic                     pkt_xfer_done,
    usb2_ep_router_if.slave          pkt,
    output logic [NUM_EP*ADDR_W-1:0] ep_buf_in_addr,
    output logic [NUM_EP*8-1:0]      ep_buf_in_data,
    output logic [NUM_EP-1:0]        ep_buf_in_wren,
    output logic [NUM_EP-1:0]        ep_buf_in_commit,
    output logic [NUM_EP*LEN_W-1:0]  ep_buf_in_commit_len,
    input  logic [NUM_EP-1:0]        ep_buf_in_ready,
    input  logic [NUM_EP-1:0]        ep_buf_in_commit_ack,
    output logic [NUM_EP*ADDR_W-1:0] ep_buf_out_addr,
    output logic [NUM_EP-1:0]        ep_buf_out_arm,
    input  logic [NUM_EP*8-1:0]      ep_buf_out_q,
    input  logic [NUM_EP*LEN_W-1:0]  ep_buf_out_len,
    input  logic [NUM_EP-1:0]        ep_buf_out_hasdata,
    input  logic [NUM_EP-1:0]        ep_buf_out_arm_ack,
    output logic [1:0]               endp_mode,
    output logic                     endp_valid,
    output logic                     endp_halted,
    input  logic                     data_toggle_act,
    output logic [1:0]               data_toggle,
    input  logic                     halt_set,
    input  logic                     halt_clr,
    input  logic [3:0]               halt_endp,
    input  logic                     toggle_reset,
    output logic [NUM_EP-1:0]        ep_active,
    output logic [NUM_EP-1:0]        ep_halt_vec,
    output logic                     err_timeout
);
    rtr_state_e        state_q, state_d;
    logic [3:0]        ep_q, ep_d;
    logic [NUM_EP-1:0] act, live, tog, halt;
    logic              token_ok, setup0, expire;

    assign token_ok = 32'(pkt_endp) < NUM_EP;
    assign setup0   = pkt_token_act && pkt_setup && pkt_endp == 4'd0;

`ifdef USB2_EP_ROUTER_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    assign wd_d   = pkt_token_act || state_q == ST_IDLE ? 16'd0 : wd_q + 16'd1;
    assign expire = state_q != ST_IDLE && !pkt_token_act && !pkt_xfer_done && wd_q == 16'(TIMEOUT - 1);
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) wd_q <= 16'd0;
        else       wd_q <= wd_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ep_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            ep_q    <= ep_d;
        end
    end

    // a new token always wins over a coincident done or watchdog expiry
    always_comb begin
        state_d = state_q;
        ep_d    = ep_q;
        if (pkt_token_act) begin
            state_d = token_ok ? ST_BOUND : ST_REJECT;
            ep_d    = pkt_endp;
        end else if (state_q != ST_IDLE && (pkt_xfer_done || expire)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        act                   = '0;
        endp_mode             = EP_MODE_CONTROL;
        pkt.buf_in_ready      = 1'b0;
        pkt.buf_in_commit_ack = 1'b0;
        pkt.buf_out_q         = '0;
        pkt.buf_out_len       = '0;
        pkt.buf_out_hasdata   = 1'b0;
        pkt.buf_out_arm_ack   = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            act[i] = state_q == ST_BOUND && ep_q == 4'(i);
            if (act[i] && i != 0) endp_mode = EP_MODES[2*i +: 2];
            if (act[i] && !halt[i]) begin
                pkt.buf_in_ready      = ep_buf_in_ready[i];
                pkt.buf_in_commit_ack = ep_buf_in_commit_ack[i];
                pkt.buf_out_q         = ep_buf_out_q[i*8 +: 8];
                pkt.buf_out_len       = ep_buf_out_len[i*LEN_W +: LEN_W];
                pkt.buf_out_hasdata   = ep_buf_out_hasdata[i];
                pkt.buf_out_arm_ack   = ep_buf_out_arm_ack[i];
            end
        end
    end

    assign live        = act & ~halt;
    assign ep_active   = act;
    assign ep_halt_vec = halt;
    assign endp_valid  = state_q == ST_BOUND;
    assign endp_halted = |(act & halt);
    assign data_toggle = |(act & tog) ? DATA1 : DATA0;
    assign err_timeout = expire;

    for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
        assign ep_buf_in_addr[g*ADDR_W +: ADDR_W]      = live[g] ? pkt.buf_in_addr : '0;
        assign ep_buf_in_data[g*8 +: 8]                = live[g] ? pkt.buf_in_data : '0;
        assign ep_buf_in_wren[g]                       = live[g] && pkt.buf_in_wren;
        assign ep_buf_in_commit[g]                     = live[g] && pkt.buf_in_commit;
        assign ep_buf_in_commit_len[g*LEN_W +: LEN_W]  = live[g] ? pkt.buf_in_commit_len : '0;
        assign ep_buf_out_addr[g*ADDR_W +: ADDR_W]     = live[g] ? pkt.buf_out_addr : '0;
        assign ep_buf_out_arm[g]                       = live[g] && pkt.buf_out_arm;
    end

    usb2_ep_state #(.NUM_EP(NUM_EP)) u_state (
        .clk            (phy_clk),
        .rst            (reset),
        .flip_i         (live & {NUM_EP{data_toggle_act}}),
        .setup0_i       (setup0),
        .halt_set_i     (halt_set),
        .halt_clr_i     (halt_clr),
        .halt_endp_i    (halt_endp),
        .toggle_reset_i (toggle_reset),
        .tog_o          (tog),
        .halt_o         (halt)
    );
endmodule

// File: tb/tb_usb2_ep_router.sv
// tb_usb2_ep_router: directed vectors with hand-computed expectations for the endpoint router
module tb_usb2_ep_router;
    localparam int N = 4, AW = 9, LW = 10;

    logic phy_clk = 1'b0, reset = 1'b1;
    logic [3:0] pkt_endp = '0, halt_endp = '0;
    logic pkt_token_act = 0, pkt_setup = 0, pkt_xfer_done = 0;
    logic data_toggle_act = 0, halt_set = 0, halt_clr = 0, toggle_reset = 0;
    logic [N*AW-1:0] ep_buf_in_addr, ep_buf_out_addr;
    logic [N*8-1:0]  ep_buf_in_data, ep_buf_out_q;
    logic [N-1:0]    ep_buf_in_wren, ep_buf_in_commit, ep_buf_out_arm;
    logic [N-1:0]    ep_buf_in_ready, ep_buf_in_commit_ack, ep_buf_out_hasdata, ep_buf_out_arm_ack;
    logic [N*LW-1:0] ep_buf_in_commit_len, ep_buf_out_len;
    logic [1:0]      endp_mode, data_toggle;
    logic            endp_valid, endp_halted, err_timeout;
    logic [N-1:0]    ep_active, ep_halt_vec;
    int total = 0, bad = 0;

    usb2_ep_router_if #(.ADDR_W(AW), .LEN_W(LW)) pkt ();

    usb2_ep_router #(.NUM_EP(N), .ADDR_W(AW), .LEN_W(LW), .EP_MODES(8'b10_10_10_00), .TIMEOUT(15)) dut (
        .phy_clk(phy_clk), .reset(reset), .pkt_endp(pkt_endp), .pkt_token_act(pkt_token_act),
        .pkt_setup(pkt_setup), .pkt_xfer_done(pkt_xfer_done), .pkt(pkt),
        .ep_buf_in_addr(ep_buf_in_addr), .ep_buf_in_data(ep_buf_in_data), .ep_buf_in_wren(ep_buf_in_wren),
        .ep_buf_in_commit(ep_buf_in_commit), .ep_buf_in_commit_len(ep_buf_in_commit_len),
        .ep_buf_in_ready(ep_buf_in_ready), .ep_buf_in_commit_ack(ep_buf_in_commit_ack),
        .ep_buf_out_addr(ep_buf_out_addr), .ep_buf_out_arm(ep_buf_out_arm), .ep_buf_out_q(ep_buf_out_q),
        .ep_buf_out_len(ep_buf_out_len), .ep_buf_out_hasdata(ep_buf_out_hasdata),
        .ep_buf_out_arm_ack(ep_buf_out_arm_ack), .endp_mode(endp_mode), .endp_valid(endp_valid),
        .endp_halted(endp_halted), .data_toggle_act(data_toggle_act), .data_toggle(data_toggle),
        .halt_set(halt_set), .halt_clr(halt_clr), .halt_endp(halt_endp), .toggle_reset(toggle_reset),
        .ep_active(ep_active), .ep_halt_vec(ep_halt_vec), .err_timeout(err_timeout)
    );

    always #5 phy_clk = ~phy_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge phy_clk);
        #1;
    endtask

    task automatic token(input logic [3:0] e, input logic s);
        pkt_endp = e;
        pkt_setup = s;
        pkt_token_act = 1;
        tick();
        pkt_token_act = 0;
        pkt_setup = 0;
        #1;
    endtask

    task automatic ack;
        data_toggle_act = 1;
        tick();
        data_toggle_act = 0;
        #1;
    endtask

    task automatic xfer_done;
        pkt_xfer_done = 1;
        tick();
        pkt_xfer_done = 0;
        #1;
    endtask

    initial begin
        pkt.buf_in_addr = '0; pkt.buf_in_data = '0; pkt.buf_in_wren = 0; pkt.buf_in_commit = 0;
        pkt.buf_in_commit_len = '0; pkt.buf_out_addr = '0; pkt.buf_out_arm = 0;
        ep_buf_in_ready = 4'b0100; ep_buf_in_commit_ack = 4'b0100; ep_buf_out_hasdata = 4'b1111;
        ep_buf_out_arm_ack = 4'b1111; ep_buf_out_q = 32'h11_3C_55_77;
        ep_buf_out_len = {10'd40, 10'd30, 10'd20, 10'd10};
        repeat (3) tick();
        check("rst_active", ep_active, 0);
        check("rst_valid", endp_valid, 0);
        check("rst_toggle", data_toggle, 0);
        check("rst_halt", ep_halt_vec, 0);
        check("rst_err", err_timeout, 0);
        reset = 0;
        tick();
        // EP2 write path and return mux
        token(2, 0);
        check("ep2_active", ep_active, 4'b0100);
        check("ep2_valid", endp_valid, 1);
        check("ep2_mode", endp_mode, 2'b10);
        pkt.buf_in_wren = 1; pkt.buf_in_data = 8'hA5; pkt.buf_in_addr = 9'd3;
        pkt.buf_in_commit = 1; pkt.buf_in_commit_len = 10'd77;
        #1;
        check("ep2_wren", ep_buf_in_wren, 4'b0100);
        check("ep2_data", ep_buf_in_data, 32'h00A5_0000);
        check("ep2_addr", ep_buf_in_addr, 64'h0_000C_0000);
        check("ep2_commit", ep_buf_in_commit, 4'b0100);
        check("ep2_clen", ep_buf_in_commit_len, 64'h4D0_0000);
        check("ep2_ready", pkt.buf_in_ready, 1);
        check("ep2_cack", pkt.buf_in_commit_ack, 1);
        check("ep2_q", pkt.buf_out_q, 8'h3C);
        check("ep2_len", pkt.buf_out_len, 10'd30);
        pkt.buf_in_wren = 0; pkt.buf_in_data = '0; pkt.buf_in_addr = '0;
        pkt.buf_in_commit = 0; pkt.buf_in_commit_len = '0;
        xfer_done();
        check("done_valid", endp_valid, 0);
        check("done_active", ep_active, 0);
        check("done_q", pkt.buf_out_q, 0);
        // out-of-range EP7
        ep_buf_in_ready = 4'b1111;
        token(7, 0);
        check("ep7_valid", endp_valid, 0);
        check("ep7_active", ep_active, 0);
        pkt.buf_in_wren = 1; pkt.buf_out_arm = 1;
        #1;
        check("ep7_wren", ep_buf_in_wren, 0);
        check("ep7_arm", ep_buf_out_arm, 0);
        check("ep7_ready", pkt.buf_in_ready, 0);
        check("ep7_armack", pkt.buf_out_arm_ack, 0);
        pkt.buf_in_wren = 0; pkt.buf_out_arm = 0;
        ack();
        xfer_done();
        // EP1 toggles and halt
        token(1, 0);
        check("ep1_active", ep_active, 4'b0010);
        check("ep1_tog0", data_toggle, 2'b00);
        ack();
        check("ep1_tog1", data_toggle, 2'b01);
        ack();
        check("ep1_tog2", data_toggle, 2'b00);
        ack();
        halt_set = 1; halt_endp = 1;
        tick();
        halt_set = 0;
        #1;
        check("ep1_hvec", ep_halt_vec, 4'b0010);
        token(1, 0);
        check("ep1_halted", endp_halted, 1);
        pkt.buf_out_arm = 1;
        #1;
        check("ep1_arm_gate", ep_buf_out_arm, 0);
        check("ep1_armack_gate", pkt.buf_out_arm_ack, 0);
        pkt.buf_out_arm = 0;
        ack();
        check("ep1_halt_noflip", data_toggle, 2'b01);
        halt_clr = 1;
        tick();
        halt_clr = 0;
        #1;
        check("ep1_clr_hvec", ep_halt_vec, 0);
        check("ep1_clr_halted", endp_halted, 0);
        check("ep1_clr_tog", data_toggle, 2'b00);
        data_toggle_act = 1; halt_clr = 1;
        tick();
        data_toggle_act = 0; halt_clr = 0;
        #1;
        check("clr_beats_ack", data_toggle, 2'b00);
        ack();
        data_toggle_act = 1; toggle_reset = 1;
        tick();
        data_toggle_act = 0; toggle_reset = 0;
        #1;
        check("trst_beats_ack", data_toggle, 2'b00);
        // toggle_reset leaves EP0 alone; SETUP resets EP0
        ack();
        token(0, 0);
        check("ep0_mode", endp_mode, 2'b00);
        check("ep0_tog0", data_toggle, 2'b00);
        ack();
        toggle_reset = 1;
        tick();
        toggle_reset = 0;
        #1;
        check("ep0_trst_kept", data_toggle, 2'b01);
        token(1, 0);
        check("ep1_trst", data_toggle, 2'b00);
        halt_set = 1; halt_endp = 0;
        tick();
        halt_set = 0;
        token(0, 0);
        check("ep0_halted", endp_halted, 1);
        check("ep0_hvec", ep_halt_vec, 4'b0001);
        check("ep0_tog_pre", data_toggle, 2'b01);
        token(0, 1);
        check("setup_tog", data_toggle, 2'b00);
        check("setup_halted", endp_halted, 0);
        check("setup_hvec", ep_halt_vec, 0);
        ack();
        data_toggle_act = 1;
        token(0, 1);
        data_toggle_act = 0;
        check("setup_beats_ack", data_toggle, 2'b00);
        // halt set/clr collision and out-of-range halt target
        halt_set = 1; halt_clr = 1; halt_endp = 3;
        tick();
        halt_clr = 0; halt_endp = 9;
        tick();
        halt_set = 0;
        #1;
        check("ep3_set_wins", ep_halt_vec, 4'b1000);
        // token beats coincident done
        token(2, 0);
        pkt_xfer_done = 1;
        token(1, 0);
        pkt_xfer_done = 0;
        check("tok_wins_active", ep_active, 4'b0010);
        check("tok_wins_valid", endp_valid, 1);
        token(1, 0);
`ifdef USB2_EP_ROUTER_TIMEOUT_EN
        repeat (13) tick();
        check("wd_c14", err_timeout, 0);
        tick();
        check("wd_c15", err_timeout, 1);
        check("wd_c15_valid", endp_valid, 1);
        tick();
        check("wd_idle", endp_valid, 0);
        check("wd_once", err_timeout, 0);
`else
        repeat (20) tick();
        check("nowd_valid", endp_valid, 1);
        check("nowd_err", err_timeout, 0);
`endif
        // asynchronous reset mid-bind
        token(2, 0);
        pkt.buf_in_wren = 1;
        #1;
        check("pre_rst_wren", ep_buf_in_wren, 4'b0100);
        #1;
        reset = 1;
        #1;
        check("arst_wren", ep_buf_in_wren, 0);
        check("arst_active", ep_active, 0);
        check("arst_hvec", ep_halt_vec, 0);
        check("arst_valid", endp_valid, 0);
        pkt.buf_in_wren = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
